// File: rtl/nivel_comporta_solicitante_pkg.sv
// State encodings for the level-driven gate request FSM, shared with the
// gate control unit debug display.
package nivel_comporta_solicitante_pkg;

    typedef enum logic [3:0] {
        OCIOSO        = 4'b0000,
        CONFIRMA_ALTO = 4'b0001,
        ABRINDO       = 4'b0010,
        ABERTA        = 4'b0011,
        FECHANDO      = 4'b0100,
        FALHA         = 4'b0101
    } estado_t;

    localparam logic [3:0] DB_INVALIDO = 4'b1111;

endpackage

// File: rtl/nivel_comporta_solicitante_contador.sv
// Saturating counter with clear/count controls; fim flags that the count
// currently sits at LIMITE.
module contador_amostras #(
    parameter int W      = 4,
    parameter int LIMITE = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_i,
    input  logic conta_i,
    output logic fim_o
);

    localparam logic [W-1:0] LIMITE_W = W'(LIMITE);

    logic [W-1:0] valor_q;
    logic [W-1:0] valor_d;

    always_comb begin
        valor_d = valor_q;
        if (zera_i) begin
            valor_d = '0;
        end else if (conta_i && (valor_q != LIMITE_W)) begin
            valor_d = valor_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign fim_o = (valor_q == LIMITE_W);

endmodule

// File: rtl/nivel_comporta_solicitante.sv
// Initiator side of the gate handshake: confirms high/low water level over
// several samples, requests the gate open/closed and supervises travel time.
module nivel_comporta_solicitante
    import nivel_comporta_solicitante_pkg::*;
#(
    parameter int NIVEL_W      = 8,
    parameter int LIMITE_ALTO  = 200,
    parameter int LIMITE_BAIXO = 100,
    parameter int AMOSTRAS     = 4,
    parameter int TIMEOUT      = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NIVEL_W-1:0] nivel,
    input  logic               nivelValido,
    input  logic               inicioPosicao,
    input  logic               fimPosicao,
    input  logic               limparFalha,
    output logic               abrirComporta,
    output logic               alarme,
    output logic [3:0]         dbEstado
);

    localparam int TEMPO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    estado_t estado_q;
    estado_t estado_d;

    logic amostraAlta;
    logic amostraBaixa;
    logic contaAmostra;
    logic limpaAmostra;
    logic zeraAmostra;
    logic fimAmostra;
    logic contaTempo;
    logic zeraTempo;
    logic fimTempo;

    assign amostraAlta  = nivelValido && (nivel > NIVEL_W'(LIMITE_ALTO));
    assign amostraBaixa = nivelValido && (nivel < NIVEL_W'(LIMITE_BAIXO));

    // fimAmostra means the pending qualifying sample is the confirming one
    contador_amostras #(.W(4), .LIMITE(AMOSTRAS - 1)) uContadorAmostras (
        .clock   (clock),
        .reset   (reset),
        .zera_i  (zeraAmostra),
        .conta_i (contaAmostra),
        .fim_o   (fimAmostra)
    );

    contador_amostras #(.W(TEMPO_W), .LIMITE(TIMEOUT - 1)) uContadorTempo (
        .clock   (clock),
        .reset   (reset),
        .zera_i  (zeraTempo),
        .conta_i (contaTempo),
        .fim_o   (fimTempo)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d     = estado_q;
        contaAmostra = 1'b0;
        limpaAmostra = 1'b0;
        contaTempo   = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (amostraAlta) begin
                    contaAmostra = 1'b1;
                    estado_d     = fimAmostra ? ABRINDO : CONFIRMA_ALTO;
                end
            end
            CONFIRMA_ALTO: begin
                if (amostraAlta) begin
                    contaAmostra = 1'b1;
                    if (fimAmostra) estado_d = ABRINDO;
                end else if (nivelValido) begin
                    estado_d = OCIOSO;
                end
            end
            ABRINDO: begin
                contaTempo = 1'b1;
                if (fimPosicao)    estado_d = ABERTA;
                else if (fimTempo) estado_d = FALHA;
            end
            ABERTA: begin
                if (amostraBaixa) begin
                    contaAmostra = 1'b1;
                    if (fimAmostra) estado_d = FECHANDO;
                end else if (nivelValido) begin
                    limpaAmostra = 1'b1;
                end
            end
            FECHANDO: begin
                contaTempo = 1'b1;
                if (inicioPosicao) estado_d = OCIOSO;
                else if (fimTempo) estado_d = FALHA;
            end
            FALHA: begin
                if (limparFalha) estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
        // Both end switches at once can only be a sensor fault
        if ((estado_q != FALHA) && inicioPosicao && fimPosicao) begin
            estado_d = FALHA;
        end
    end

    // The first alto sample carries its count into confirmaAlto
    assign zeraTempo   = (estado_d != estado_q);
    assign zeraAmostra = limpaAmostra ||
                         (zeraTempo && !((estado_q == OCIOSO) && (estado_d == CONFIRMA_ALTO)));

    always_comb begin
        abrirComporta = 1'b0;
        alarme        = 1'b0;
        dbEstado      = DB_INVALIDO;
        case (estado_q)
            OCIOSO, CONFIRMA_ALTO, FECHANDO: dbEstado = estado_q;
            ABRINDO, ABERTA: begin
                dbEstado      = estado_q;
                abrirComporta = 1'b1;
            end
            FALHA: begin
                dbEstado = estado_q;
                alarme   = 1'b1;
            end
            default: dbEstado = DB_INVALIDO;
        endcase
    end

endmodule

// File: tb/tb_nivel_comporta_solicitante.sv
// Directed self-checking bench for nivel_comporta_solicitante with default
// parameters (AMOSTRAS=4, TIMEOUT=1000).
module tb_nivel_comporta_solicitante;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] nivel;
    logic       nivelValido;
    logic       inicioPosicao;
    logic       fimPosicao;
    logic       limparFalha;
    logic       abrirComporta;
    logic       alarme;
    logic [3:0] dbEstado;

    int checks = 0;
    int errors = 0;

    nivel_comporta_solicitante dut (
        .clock         (clock),
        .reset         (reset),
        .nivel         (nivel),
        .nivelValido   (nivelValido),
        .inicioPosicao (inicioPosicao),
        .fimPosicao    (fimPosicao),
        .limparFalha   (limparFalha),
        .abrirComporta (abrirComporta),
        .alarme        (alarme),
        .dbEstado      (dbEstado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sendSample(input logic [7:0] v);
        nivel       = v;
        nivelValido = 1'b1;
        tick();
        nivelValido = 1'b0;
    endtask

    // Four alto samples: leaves the DUT in the first cycle of abrindo
    task automatic openRequest();
        for (int i = 0; i < 4; i++) sendSample(8'd210);
    endtask

    task automatic reachAberta();
        openRequest();
        fimPosicao = 1'b1;
        tick();
        fimPosicao = 1'b0;
    endtask

    task automatic reachFechando();
        reachAberta();
        for (int i = 0; i < 4; i++) sendSample(8'd90);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        nivel = '0; nivelValido = 0; inicioPosicao = 0; fimPosicao = 0; limparFalha = 0;
        ticks(2);
        checks++;
        if ({abrirComporta, alarme, dbEstado} !== 6'b00_0000) begin
            errors++;
            $display("[TB] FAIL reset: abrir=%b alarme=%b db=%b expected 0 0 0000", abrirComporta, alarme, dbEstado);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (dbEstado !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_release: db=%b expected 0000", dbEstado);
        end
    endtask

    task automatic test_normal_cycle();
        sendSample(8'd210);
        checks++;
        if (dbEstado !== 4'b0001) begin
            errors++; $display("[TB] FAIL normal_first_alto: db=%b expected 0001", dbEstado);
        end
        sendSample(8'd210);
        sendSample(8'd210);
        checks++;
        if ({abrirComporta, dbEstado} !== 5'b0_0001) begin
            errors++; $display("[TB] FAIL normal_third_alto: abrir=%b db=%b expected 0 0001", abrirComporta, dbEstado);
        end
        sendSample(8'd210);
        checks++;
        if ({abrirComporta, dbEstado} !== 5'b1_0010) begin
            errors++; $display("[TB] FAIL normal_abrindo: abrir=%b db=%b expected 1 0010", abrirComporta, dbEstado);
        end
        ticks(19);
        fimPosicao = 1'b1;
        tick();
        fimPosicao = 1'b0;
        checks++;
        if ({abrirComporta, dbEstado} !== 5'b1_0011) begin
            errors++; $display("[TB] FAIL normal_aberta: abrir=%b db=%b expected 1 0011", abrirComporta, dbEstado);
        end
        for (int i = 0; i < 3; i++) sendSample(8'd90);
        checks++;
        if ({abrirComporta, dbEstado} !== 5'b1_0011) begin
            errors++; $display("[TB] FAIL normal_third_baixo: abrir=%b db=%b expected 1 0011", abrirComporta, dbEstado);
        end
        sendSample(8'd90);
        checks++;
        if ({abrirComporta, dbEstado} !== 5'b0_0100) begin
            errors++; $display("[TB] FAIL normal_fechando: abrir=%b db=%b expected 0 0100", abrirComporta, dbEstado);
        end
        inicioPosicao = 1'b1;
        tick();
        inicioPosicao = 1'b0;
        checks++;
        if (dbEstado !== 4'b0000) begin
            errors++; $display("[TB] FAIL normal_closed: db=%b expected 0000", dbEstado);
        end
    endtask

    task automatic test_hysteresis();
        sendSample(8'd210);
        sendSample(8'd210);
        sendSample(8'd150);
        checks++;
        if ({abrirComporta, dbEstado} !== 5'b0_0000) begin
            errors++; $display("[TB] FAIL hyst_break: abrir=%b db=%b expected 0 0000", abrirComporta, dbEstado);
        end
        sendSample(8'd210);
        checks++;
        if ({abrirComporta, dbEstado} !== 5'b0_0001) begin
            errors++; $display("[TB] FAIL hyst_restart: abrir=%b db=%b expected 0 0001", abrirComporta, dbEstado);
        end
        sendSample(8'd150);
        for (int i = 0; i < 5; i++) sendSample(8'd200);
        checks++;
        if (dbEstado !== 4'b0000) begin
            errors++; $display("[TB] FAIL hyst_exact_200: db=%b expected 0000", dbEstado);
        end
        reachAberta();
        sendSample(8'd90);
        sendSample(8'd90);
        sendSample(8'd120);
        sendSample(8'd90);
        sendSample(8'd90);
        sendSample(8'd90);
        checks++;
        if ({abrirComporta, dbEstado} !== 5'b1_0011) begin
            errors++; $display("[TB] FAIL hyst_baixo_reset: abrir=%b db=%b expected 1 0011", abrirComporta, dbEstado);
        end
        sendSample(8'd100);
        sendSample(8'd90);
        sendSample(8'd90);
        sendSample(8'd90);
        checks++;
        if (dbEstado !== 4'b0011) begin
            errors++; $display("[TB] FAIL hyst_exact_100: db=%b expected 0011", dbEstado);
        end
        sendSample(8'd90);
        checks++;
        if ({abrirComporta, dbEstado} !== 5'b0_0100) begin
            errors++; $display("[TB] FAIL hyst_close: abrir=%b db=%b expected 0 0100", abrirComporta, dbEstado);
        end
        inicioPosicao = 1'b1;
        tick();
        inicioPosicao = 1'b0;
    endtask

    task automatic test_open_timeout();
        openRequest();
        ticks(999);
        checks++;
        if (dbEstado !== 4'b0010) begin
            errors++; $display("[TB] FAIL open_timeout_early: db=%b expected 0010", dbEstado);
        end
        tick();
        checks++;
        if ({abrirComporta, alarme, dbEstado} !== 6'b01_0101) begin
            errors++; $display("[TB] FAIL open_timeout: abrir=%b alarme=%b db=%b expected 0 1 0101", abrirComporta, alarme, dbEstado);
        end
        ticks(3);
        checks++;
        if (dbEstado !== 4'b0101) begin
            errors++; $display("[TB] FAIL falha_latched: db=%b expected 0101", dbEstado);
        end
        limparFalha = 1'b1;
        tick();
        limparFalha = 1'b0;
        checks++;
        if ({alarme, dbEstado} !== 5'b0_0000) begin
            errors++; $display("[TB] FAIL limpar_falha: alarme=%b db=%b expected 0 0000", alarme, dbEstado);
        end
    endtask

    task automatic test_close_timeout();
        reachFechando();
        ticks(999);
        checks++;
        if (dbEstado !== 4'b0100) begin
            errors++; $display("[TB] FAIL close_timeout_early: db=%b expected 0100", dbEstado);
        end
        tick();
        checks++;
        if ({alarme, dbEstado} !== 5'b1_0101) begin
            errors++; $display("[TB] FAIL close_timeout: alarme=%b db=%b expected 1 0101", alarme, dbEstado);
        end
        limparFalha = 1'b1;
        tick();
        limparFalha = 1'b0;
    endtask

    task automatic test_tie();
        openRequest();
        ticks(999);
        fimPosicao = 1'b1;
        tick();
        fimPosicao = 1'b0;
        checks++;
        if ({alarme, dbEstado} !== 5'b0_0011) begin
            errors++; $display("[TB] FAIL tie_open: alarme=%b db=%b expected 0 0011", alarme, dbEstado);
        end
        for (int i = 0; i < 4; i++) sendSample(8'd90);
        ticks(999);
        inicioPosicao = 1'b1;
        tick();
        inicioPosicao = 1'b0;
        checks++;
        if ({alarme, dbEstado} !== 5'b0_0000) begin
            errors++; $display("[TB] FAIL tie_close: alarme=%b db=%b expected 0 0000", alarme, dbEstado);
        end
    endtask

    task automatic test_illegal_feedback();
        reachAberta();
        inicioPosicao = 1'b1;
        fimPosicao    = 1'b1;
        tick();
        inicioPosicao = 1'b0;
        fimPosicao    = 1'b0;
        checks++;
        if ({abrirComporta, alarme, dbEstado} !== 6'b01_0101) begin
            errors++; $display("[TB] FAIL illegal_feedback: abrir=%b alarme=%b db=%b expected 0 1 0101", abrirComporta, alarme, dbEstado);
        end
        limparFalha = 1'b1;
        tick();
        limparFalha = 1'b0;
    endtask

    task automatic test_async_reset();
        openRequest();
        checks++;
        if (abrirComporta !== 1'b1) begin
            errors++; $display("[TB] FAIL async_pre: abrir=%b expected 1", abrirComporta);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({abrirComporta, dbEstado} !== 5'b0_0000) begin
            errors++; $display("[TB] FAIL async_reset: abrir=%b db=%b expected 0 0000", abrirComporta, dbEstado);
        end
        #1;
        reset = 1'b0;
        ticks(3);
        checks++;
        if ({abrirComporta, dbEstado} !== 5'b0_0000) begin
            errors++; $display("[TB] FAIL async_after: abrir=%b db=%b expected 0 0000", abrirComporta, dbEstado);
        end
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_hysteresis();
        test_open_timeout();
        test_close_timeout();
        test_tie();
        test_illegal_feedback();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
